bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
Shared sequential binary-to-BCD conversion engine with a two-requester round-robin arbiter.
- Each requester submits a W-bit binary value and receives a 4*D-bit packed BCD result with a one-cycle ack.
- The engine is an iterative shift-and-add-3 (double-dabble) datapath that processes one bit per clock.
- Sits between the counter/measurement logic and the display-driver logic, replacing per-consumer combinational converters.

Parameters:
W, 10, binary operand width
D, 4, BCD digit count; must satisfy 10^D > 2^W - 1 (W=10 -> D=4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 conversion request, level
bin0  input  W  requester 0 operand
req1  input  1  requester 1 conversion request, level
bin1  input  W  requester 1 operand
ack0  output  1  one-cycle pulse: bcd0 updated
bcd0  output  4*D  requester 0 result; digit k in bits [4k+3:4k], k=0 is units
ack1  output  1  one-cycle pulse: bcd1 updated
bcd1  output  4*D  requester 1 result
busy  output  1  high whenever the engine is not IDLE

Behaviour:
- Reset: state=IDLE, ack0=ack1=0, bcd0=bcd1=0, busy=0, shift register=0, bit counter=0, last_grant=1 (so requester 0 wins the first tie). Reset overrides every other event, including mid-conversion. An aborted conversion produces no ack and writes no result.
- FSM states: IDLE, CONV, DONE. busy = (state != IDLE).
- IDLE, at a clock edge (E0):
  - if no req is high: stay in IDLE.
  - if exactly one req is high: grant that requester.
  - if both are high: grant the requester != last_grant.
  - On a grant: register the grant index, set last_grant to it, load the shift register with {4*D zeros, granted bin}, clear the counter, go to CONV.
  - The operand is captured only at E0; later changes to binX are ignored.
- CONV, each edge:
  - For every digit field >= 5, add 3 (4-bit, no carry-out).
  - Then shift the whole {digits, operand} register left by 1.
  - Increment the counter.
  - On the edge that performs step W, the corrected-and-shifted digit field is written to bcdX of the granted requester, ackX is set to 1, and the FSM goes to DONE.
- DONE: lasts exactly one cycle. ackX is high during it. At the next edge ackX returns to 0 and the FSM goes to IDLE.
- Latency: the ack is high in the cycle following edge E0+W (W=10: 10 edges after the grant edge). Throughput: one conversion per W+2 cycles.
- Handshake:
  - A requester holds reqX high until it sees ackX.
  - It deasserts reqX in the ack cycle, or the request is treated as a new request in the next IDLE cycle.
  - Requests arriving while busy wait; they are sampled only in IDLE, and none are lost while held high.
- Results:
  - bcdX holds its value until that requester's next completed conversion.
  - The non-granted requester's outputs never change.
  - The unused bcd output of a requester never glitches during the other requester's conversion.
- Fairness: under continuous requests on both channels, grants strictly alternate 0,1,0,1...
- Arithmetic: digits are exact for every operand 0..2^W-1. No overflow is possible given the D constraint.

Test Plan:
- Reset, then req0=1, bin0=1023 -> ack0 pulses for exactly one cycle, 10 edges after the grant edge; bcd0=16'h1023; ack1=0 and bcd1=16'h0000 throughout.
- Single requests bin1=0, then 999, then 512 -> bcd1 = 16'h0000, 16'h0999, 16'h0512 respectively; busy high from the grant edge through the DONE cycle.
- Both req held from reset with bin0=100, bin1=37 -> grant order 0,1,0,1; bcd0=16'h0100, bcd1=16'h0037; acks alternate with 12-cycle spacing.
- bin0 changed from 255 to 7 two cycles after grant -> bcd0=16'h0255; the change is ignored.
- rst asserted 5 cycles into a conversion of bin0=800 -> next cycle busy=0, ack0 never pulses, bcd0=0. A new request of 800 afterwards yields 16'h0800 with full latency.
- Exhaustive sweep 0..1023 on requester 0 against a reference model -> every ack carries the correct BCD; no ack is missed or duplicated.

Source files
------------

// File: rtl/bcd_conv_sched_if.sv
// Requester-side bundle for the shared binary-to-BCD engine.
// It carries two request/operand channels, their ack/result channels, and the engine busy flag.
interface bcd_conv_sched_if #(
  parameter int W = 10,
  parameter int D = 4
);
  logic           req0;
  logic [W-1:0]   bin0;
  logic           req1;
  logic [W-1:0]   bin1;
  logic           ack0;
  logic [4*D-1:0] bcd0;
  logic           ack1;
  logic [4*D-1:0] bcd1;
  logic           busy;

  modport master (
    output req0, bin0, req1, bin1,
    input  ack0, bcd0, ack1, bcd1, busy
  );

  modport slave (
    input  req0, bin0, req1, bin1,
    output ack0, bcd0, ack1, bcd1, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared double-dabble binary-to-BCD engine, one bit per clock.
// Two requesters share it through a round-robin arbiter.
module bcd_conv_sched #(
  parameter int W = 10,
  parameter int D = 4
) (
  input  logic            clk,
  input  logic            rst,
  bcd_conv_sched_if.slave bus
);
  localparam int SW = 4*D + W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [CW-1:0]   cnt;
  logic            grant;
  logic            last_grant;
  logic [4*D-1:0]  digits_adj;
  logic [SW-1:0]   sr_next;
  logic            pick1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digits_adj = sr[SW-1:W];
    for (int k = 0; k < D; k++) begin
      if (digits_adj[4*k +: 4] >= 4'd5)
        digits_adj[4*k +: 4] = digits_adj[4*k +: 4] + 4'd3;
    end
    sr_next = {digits_adj, sr[W-1:0]} << 1;
  end

  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign pick1 = bus.req1 && (!bus.req0 || !last_grant);

  assign bus.busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is cleared like any other state.
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.bcd0   <= '0;
      bus.bcd1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant      <= pick1;
            last_grant <= pick1;
            sr         <= {{(4*D){1'b0}}, (pick1 ? bus.bin1 : bus.bin0)};
            cnt        <= '0;
            state      <= CONV;
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            if (grant) begin
              bus.bcd1 <= sr_next[SW-1:W];
              bus.ack1 <= 1'b1;
            end else begin
              bus.bcd0 <= sr_next[SW-1:W];
              bus.ack0 <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: latency, arbitration, operand capture,
// reset abort and a full operand sweep against a decimal reference.
module tb_bcd_conv_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] exp_bcd0 = 16'h0000;
  logic [15:0] exp_bcd1 = 16'h0000;

  bcd_conv_sched_if #(.W(10), .D(4)) bus ();

  bcd_conv_sched #(.W(10), .D(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // One full request on channel ch; if alt >= 0 the operand is changed two cycles after the grant.
  task automatic run_req(input int ch, input int val, input int alt);
    int          n;
    logic        busy_ok;
    logic        other_quiet;
    logic [15:0] exp;
    exp = to_bcd(val);
    if (ch == 0) begin bus.req0 = 1'b1; bus.bin0 = 10'(val); end
    else         begin bus.req1 = 1'b1; bus.bin1 = 10'(val); end
    tick();
    check("busy_at_grant", 32'(bus.busy), 32'd1);
    n = 0;
    busy_ok = 1'b1;
    other_quiet = 1'b1;
    while (!(ch == 0 ? bus.ack0 : bus.ack1) && n < 40) begin
      if (n == 2 && alt >= 0) begin
        if (ch == 0) bus.bin0 = 10'(alt);
        else         bus.bin1 = 10'(alt);
      end
      busy_ok     &= bus.busy;
      other_quiet &= (ch == 0) ? !bus.ack1 && (bus.bcd1 == exp_bcd1)
                               : !bus.ack0 && (bus.bcd0 == exp_bcd0);
      tick();
      n++;
    end
    check("ack_latency", 32'(n), 32'd10);
    check("busy_during_conv", 32'(busy_ok && bus.busy), 32'd1);
    check("other_channel_quiet", 32'(other_quiet), 32'd1);
    check("result", 32'(ch == 0 ? bus.bcd0 : bus.bcd1), 32'(exp));
    check("other_ack_low", 32'(ch == 0 ? bus.ack1 : bus.ack0), 32'd0);
    if (ch == 0) begin bus.req0 = 1'b0; exp_bcd0 = exp; end
    else         begin bus.req1 = 1'b0; exp_bcd1 = exp; end
    tick();
    check("ack_one_cycle", 32'(ch == 0 ? bus.ack0 : bus.ack1), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("result_held", 32'(ch == 0 ? bus.bcd0 : bus.bcd1), 32'(exp));
  endtask

  initial begin
    int ev_ch [4];
    int ev_t  [4];
    int ne;
    int n;
    logic quiet;

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.bin0 = '0;   bus.bin1 = '0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_bcd0", 32'(bus.bcd0), 32'h0);
    check("rst_bcd1", 32'(bus.bcd1), 32'h0);
    rst = 1'b0;
    tick();

    run_req(0, 1023, -1);
    check("bcd0_1023", 32'(bus.bcd0), 32'h1023);
    run_req(1, 0, -1);
    check("bcd1_0", 32'(bus.bcd1), 32'h0000);
    run_req(1, 999, -1);
    check("bcd1_999", 32'(bus.bcd1), 32'h0999);
    run_req(1, 512, -1);
    check("bcd1_512", 32'(bus.bcd1), 32'h0512);

    // Both requests held from reset: grants alternate starting with requester 0.
    rst = 1'b1;
    bus.req0 = 1'b1; bus.bin0 = 10'd100;
    bus.req1 = 1'b1; bus.bin1 = 10'd37;
    tick();
    rst = 1'b0;
    ne = 0;
    for (int t = 0; t < 52; t++) begin
      tick();
      if ((bus.ack0 || bus.ack1) && ne < 4) begin
        ev_ch[ne] = bus.ack1 ? 1 : 0;
        ev_t[ne]  = t;
        ne++;
      end
    end
    check("rr_event_count", 32'(ne), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 32'(ev_ch[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) check("rr_spacing", 32'(ev_t[i] - ev_t[i-1]), 32'd12);
    check("rr_bcd0", 32'(bus.bcd0), 32'h0100);
    check("rr_bcd1", 32'(bus.bcd1), 32'h0037);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin tick(); n++; end
    check("rr_drain", 32'(bus.busy), 32'd0);
    exp_bcd0 = 16'h0100;
    exp_bcd1 = 16'h0037;

    run_req(0, 255, 7);
    check("capture_ignores_change", 32'(bus.bcd0), 32'h0255);

    // Reset five cycles into a conversion aborts it without an ack or a result.
    bus.req0 = 1'b1; bus.bin0 = 10'd800;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.req0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ack0", 32'(bus.ack0), 32'd0);
    check("abort_bcd0", 32'(bus.bcd0), 32'h0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); quiet &= !bus.ack0 && !bus.busy; end
    check("abort_no_ack", 32'(quiet), 32'd1);
    exp_bcd0 = 16'h0000;
    exp_bcd1 = 16'h0000;
    run_req(0, 800, -1);
    check("bcd0_800", 32'(bus.bcd0), 32'h0800);

    for (int v = 0; v < 1024; v++) run_req(0, v, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
